// File: rtl/snn_frame_ctrl.sv
// snn_frame_ctrl: frame sequencer for the SNN digit classifier.
// Loads a packed binary image from UART bytes into the input-unit RAM
// one bit per cycle, starts the core, then returns the classified digit
// over UART TX.
module snn_frame_ctrl #(
  parameter int NUM_BITS  = 784,
  parameter int ADDR_W    = 10,
  parameter int ASCII_OUT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wdata,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_rdy,
  output logic [3:0]        digit,
  output logic              busy,
  output logic              overrun
);

  localparam int NUM_BYTES = NUM_BITS / 8;
  localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef enum logic [2:0] {
    WAIT_BYTE  = 3'd0,
    WRITE      = 3'd1,
    START      = 3'd2,
    WAIT_CORE  = 3'd3,
    SEND       = 3'd4,
    WAIT_TX_LO = 3'd5,
    WAIT_TX_HI = 3'd6
  } state_t;

  state_t              state_reg, state_next;
  logic [7:0]          shift_reg, shift_next;
  logic [2:0]          bit_cnt_reg, bit_cnt_next;
  logic [BYTE_W-1:0]   byte_cnt_reg, byte_cnt_next;
  logic [ADDR_W-1:0]   load_addr_reg, load_addr_next;
  logic [3:0]          digit_reg, digit_next;
  logic [7:0]          tx_data_reg, tx_data_next;
  logic                overrun_reg, overrun_next;
  logic [7:0]          digit_code;

  // Byte sent back to the host: printable ASCII digit or raw nibble.
  assign digit_code = (ASCII_OUT != 0) ? (8'h30 + {4'h0, core_digit})
                                       : {4'h0, core_digit};

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= WAIT_BYTE;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      byte_cnt_reg  <= '0;
      load_addr_reg <= '0;
      digit_reg     <= '0;
      tx_data_reg   <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      bit_cnt_reg   <= bit_cnt_next;
      byte_cnt_reg  <= byte_cnt_next;
      load_addr_reg <= load_addr_next;
      digit_reg     <= digit_next;
      tx_data_reg   <= tx_data_next;
      overrun_reg   <= overrun_next;
    end
  end

  // Next-state, counter updates and one-cycle strobes.
  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    bit_cnt_next   = bit_cnt_reg;
    byte_cnt_next  = byte_cnt_reg;
    load_addr_next = load_addr_reg;
    digit_next     = digit_reg;
    tx_data_next   = tx_data_reg;
    overrun_next   = overrun_reg;
    ram_we         = 1'b0;
    ram_wdata      = 1'b0;
    core_start     = 1'b0;
    tx_start       = 1'b0;

    // A byte arriving while we cannot accept it is dropped and flagged.
    if (rx_rdy && (state_reg != WAIT_BYTE)) begin
      overrun_next = 1'b1;
    end

    case (state_reg)
      WAIT_BYTE: begin
        if (rx_rdy) begin
          shift_next   = rx_data;
          bit_cnt_next = 3'd0;
          state_next   = WRITE;
          // The first byte of a new frame starts with a clean flag.
          if (byte_cnt_reg == '0) begin
            overrun_next = 1'b0;
          end
        end
      end
      WRITE: begin
        ram_we       = 1'b1;
        ram_wdata    = shift_reg[0];
        shift_next   = {1'b0, shift_reg[7:1]};
        bit_cnt_next = bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          if (byte_cnt_reg == BYTE_W'(NUM_BYTES - 1)) begin
            // Last pixel written: rewind so the address stays in range.
            byte_cnt_next  = '0;
            load_addr_next = '0;
            state_next     = START;
          end else begin
            byte_cnt_next  = byte_cnt_reg + BYTE_W'(1);
            load_addr_next = load_addr_reg + ADDR_W'(1);
            state_next     = WAIT_BYTE;
          end
        end else begin
          load_addr_next = load_addr_reg + ADDR_W'(1);
        end
      end
      START: begin
        core_start = 1'b1;
        state_next = WAIT_CORE;
      end
      WAIT_CORE: begin
        if (core_done) begin
          digit_next   = core_digit;
          tx_data_next = digit_code;
          state_next   = SEND;
        end
      end
      SEND: begin
        if (tx_rdy) begin
          tx_start   = 1'b1;
          state_next = WAIT_TX_LO;
        end
      end
      WAIT_TX_LO: begin
        if (!tx_rdy) begin
          state_next = WAIT_TX_HI;
        end
      end
      WAIT_TX_HI: begin
        if (tx_rdy) begin
          state_next = WAIT_BYTE;
        end
      end
      default: begin
        state_next = WAIT_BYTE;
      end
    endcase
  end

  // RAM port belongs to the loader only while it is writing.
  assign ram_addr = (state_reg == WRITE) ? load_addr_reg : core_addr;
  assign tx_data  = tx_data_reg;
  assign digit    = digit_reg;
  assign busy     = (state_reg != WAIT_BYTE);
  assign overrun  = overrun_reg;

endmodule

// File: tb/tb_snn_frame_ctrl.sv
// Testbench for snn_frame_ctrl: scoreboarded RAM writes and TX bytes.
module tb_snn_frame_ctrl;

  localparam int NB  = 98;
  localparam int OBS = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [9:0] core_addr = 10'd0;
  logic       core_done = 1'b0;
  logic [3:0] core_digit = 4'd0;
  logic       tx_rdy = 1'b1;

  logic       ram_we, ram_wdata, core_start, tx_start, busy, overrun;
  logic [9:0] ram_addr;
  logic [7:0] tx_data;
  logic [3:0] digit;

  logic       b_ram_we, b_ram_wdata, b_core_start, b_tx_start, b_busy, b_overrun;
  logic [9:0] b_ram_addr;
  logic [7:0] b_tx_data;
  logic [3:0] b_digit;

  snn_frame_ctrl #(.NUM_BITS(784), .ADDR_W(10), .ASCII_OUT(1)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .core_addr(core_addr), .core_start(core_start), .core_done(core_done),
    .core_digit(core_digit), .tx_start(tx_start), .tx_data(tx_data),
    .tx_rdy(tx_rdy), .digit(digit), .busy(busy), .overrun(overrun)
  );

  snn_frame_ctrl #(.NUM_BITS(784), .ADDR_W(10), .ASCII_OUT(0)) dut_raw (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
    .core_addr(core_addr), .core_start(b_core_start), .core_done(core_done),
    .core_digit(core_digit), .tx_start(b_tx_start), .tx_data(b_tx_data),
    .tx_rdy(tx_rdy), .digit(b_digit), .busy(b_busy), .overrun(b_overrun)
  );

  always #5 clk = ~clk;

  // Counters and scoreboard
  int n_cmp = 0;
  int n_err = 0;
  int rd_n  = 0;
  logic [10:0] exp_q[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  exp_tx0[$];

  // Monitor state (written only by the monitor processes)
  int cyc = 0;
  int wr_n = 0;
  int last_we_cyc = 0;
  int cs_n = 0;
  int cs_cyc = 0;
  int tx_n = 0;
  int tx_cyc = 0;
  int tx_bad = 0;
  logic [9:0] obs_a[OBS];
  logic       obs_b[OBS];
  logic [7:0] tx_log[64];
  logic [7:0] tx0_log[64];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every DUT event away from the active edge
  always @(negedge clk) begin
    if (ram_we && wr_n < OBS) begin
      obs_a[wr_n] <= ram_addr;
      obs_b[wr_n] <= ram_wdata;
      wr_n        <= wr_n + 1;
      last_we_cyc <= cyc;
    end
    if (core_start) begin
      cs_n   <= cs_n + 1;
      cs_cyc <= cyc;
    end
    if (tx_start && tx_n < 64) begin
      tx_log[tx_n]  <= tx_data;
      tx0_log[tx_n] <= b_tx_data;
      tx_n          <= tx_n + 1;
      tx_cyc        <= cyc;
      if (!tx_rdy) tx_bad <= tx_bad + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int sel, input int k);
    if (sel == 0) return 8'hA5;
    return 8'((k * sel) ^ (sel * 17) ^ (k >> 2));
  endfunction

  // Drive one accepted byte and queue its eight expected RAM writes
  task automatic send_byte(input logic [7:0] b, input int k);
    for (int i = 0; i < 8; i++) exp_q.push_back({10'(k * 8 + i), b[i]});
    rx_data = b;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy = 1'b0;
    repeat (9) tick();
  endtask

  task automatic send_frame(input int sel);
    for (int k = 0; k < NB; k++) send_byte(pat(sel, k), k);
  endtask

  task automatic drive_done(input logic [3:0] d, output int edge_cyc);
    exp_tx.push_back(8'h30 + {4'h0, d});
    exp_tx0.push_back({4'h0, d});
    core_digit = d;
    core_done  = 1'b1;
    tick();
    core_done = 1'b0;
    edge_cyc  = cyc;
  endtask

  // Bounded wait for a tx_start, then model the UART going busy and idle
  task automatic wait_tx(input int n0, input int post, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (tx_n > n0) ok = 1'b1;
    end
    if (ok) begin
      tx_rdy = 1'b0;
      repeat (4) tick();
      tx_rdy = 1'b1;
      repeat (post) tick();
    end
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    n_cmp++; if (ram_addr !== 10'd0) begin n_err++; $display("FAIL reset_ram_addr: got %0d want 0", ram_addr); end
    n_cmp++; if (core_start !== 1'b0 || tx_start !== 1'b0 || ram_wdata !== 1'b0) begin n_err++; $display("FAIL reset_strobes: got %b%b%b want 000", core_start, tx_start, ram_wdata); end
    e = tx_data;
    n_cmp++; if (e !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", e); end
    n_cmp++; if (digit !== 4'd0 || busy !== 1'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL reset_status: got digit=%0d busy=%b ovr=%b want 0 0 0", digit, busy, overrun); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_frame_a5();
    int w0, cs0, t0, de;
    bit ok;
    logic [10:0] e;
    w0 = wr_n; cs0 = cs_n; t0 = tx_n;
    send_frame(0);
    repeat (2) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rd_n >= wr_n) begin n_err++; $display("FAIL a5_write: got none want addr %0d bit %b", e[10:1], e[0]); end
      else begin
        if ({obs_a[rd_n], obs_b[rd_n]} !== e) begin n_err++; $display("FAIL a5_write: got addr %0d bit %b want addr %0d bit %b", obs_a[rd_n], obs_b[rd_n], e[10:1], e[0]); end
        rd_n++;
      end
    end
    n_cmp++; if (wr_n - w0 != 784) begin n_err++; $display("FAIL a5_we_count: got %0d want 784", wr_n - w0); end
    n_cmp++; if (cs_n - cs0 != 1) begin n_err++; $display("FAIL a5_start_count: got %0d want 1", cs_n - cs0); end
    n_cmp++; if (cs_cyc != last_we_cyc + 1) begin n_err++; $display("FAIL a5_start_lat: got %0d want %0d", cs_cyc, last_we_cyc + 1); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL a5_busy_core: got %b want 1", busy); end
    core_addr = 10'h155;
    #1;
    n_cmp++; if (ram_addr !== 10'h155) begin n_err++; $display("FAIL a5_addr_mux: got %h want 155", ram_addr); end
    core_addr = 10'd0;
    drive_done(4'd7, de);
    wait_tx(t0, 2, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL a5_tx_timeout: got no tx_start want one"); end
    n_cmp++; if (tx_n - t0 != 1) begin n_err++; $display("FAIL a5_tx_count: got %0d want 1", tx_n - t0); end
    n_cmp++; if (tx_cyc != de) begin n_err++; $display("FAIL a5_tx_lat: got %0d want %0d", tx_cyc, de); end
    e = {3'b0, exp_tx.pop_front()};
    n_cmp++; if (tx_log[tx_n-1] !== e[7:0]) begin n_err++; $display("FAIL a5_tx_ascii: got %h want %h", tx_log[tx_n-1], e[7:0]); end
    e = {3'b0, exp_tx0.pop_front()};
    n_cmp++; if (tx0_log[tx_n-1] !== e[7:0]) begin n_err++; $display("FAIL a5_tx_raw: got %h want %h", tx0_log[tx_n-1], e[7:0]); end
    n_cmp++; if (digit !== 4'd7 || tx_data !== 8'h37) begin n_err++; $display("FAIL a5_held: got digit=%0d tx=%h want 7 37", digit, tx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL a5_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_tx_stall();
    int t0, de;
    bit ok, busy_low;
    logic [7:0] e;
    logic [10:0] w;
    send_frame(3);
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front(); n_cmp++;
      if (rd_n >= wr_n) begin n_err++; $display("FAIL stall_write: got none want addr %0d", w[10:1]); end
      else begin
        if ({obs_a[rd_n], obs_b[rd_n]} !== w) begin n_err++; $display("FAIL stall_write: got addr %0d bit %b want addr %0d bit %b", obs_a[rd_n], obs_b[rd_n], w[10:1], w[0]); end
        rd_n++;
      end
    end
    t0 = tx_n;
    tx_rdy = 1'b0;
    drive_done(4'd4, de);
    busy_low = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (busy !== 1'b1) busy_low = 1'b1;
    end
    n_cmp++; if (tx_n != t0) begin n_err++; $display("FAIL stall_no_pulse: got %0d pulses want 0", tx_n - t0); end
    n_cmp++; if (busy_low) begin n_err++; $display("FAIL stall_busy: got low want high"); end
    tx_rdy = 1'b1;
    wait_tx(t0, 2, ok);
    n_cmp++; if (!ok || tx_n - t0 != 1) begin n_err++; $display("FAIL stall_tx_count: got %0d want 1", tx_n - t0); end
    e = exp_tx.pop_front(); void'(exp_tx0.pop_front());
    n_cmp++; if (tx_log[tx_n-1] !== e) begin n_err++; $display("FAIL stall_tx_data: got %h want %h", tx_log[tx_n-1], e); end
    n_cmp++; if (tx_bad != 0) begin n_err++; $display("FAIL stall_tx_low: got %0d pulses while low want 0", tx_bad); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stall_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_overrun();
    int t0, cs0, w1, de;
    bit ok;
    logic [7:0] e;
    logic [10:0] w;
    cs0 = cs_n; t0 = tx_n;
    for (int i = 0; i < 8; i++) exp_q.push_back({10'(i), pat(5, 0)});
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      e = pat(5, 0);
      exp_q.push_back({10'(i), e[i]});
    end
    rx_data = pat(5, 0); rx_rdy = 1'b1; tick(); rx_rdy = 1'b0;
    repeat (2) tick();
    rx_data = 8'hFF; rx_rdy = 1'b1; tick(); rx_rdy = 1'b0;
    repeat (6) tick();
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_write: got %b want 1", overrun); end
    for (int k = 1; k < NB; k++) send_byte(pat(5, k), k);
    w1 = wr_n;
    rx_data = 8'h00; rx_rdy = 1'b1; tick(); rx_rdy = 1'b0; repeat (3) tick();
    n_cmp++; if (overrun !== 1'b1 || busy !== 1'b1 || wr_n != w1) begin n_err++; $display("FAIL ovr_core: got ovr=%b busy=%b writes=%0d want 1 1 0", overrun, busy, wr_n - w1); end
    n_cmp++; if (cs_n - cs0 != 1) begin n_err++; $display("FAIL ovr_start_count: got %0d want 1", cs_n - cs0); end
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front(); n_cmp++;
      if (rd_n >= wr_n) begin n_err++; $display("FAIL ovr_write_sb: got none want addr %0d", w[10:1]); end
      else begin
        if ({obs_a[rd_n], obs_b[rd_n]} !== w) begin n_err++; $display("FAIL ovr_write_sb: got addr %0d bit %b want addr %0d bit %b", obs_a[rd_n], obs_b[rd_n], w[10:1], w[0]); end
        rd_n++;
      end
    end
    n_cmp++; if (wr_n != rd_n) begin n_err++; $display("FAIL ovr_extra_writes: got %0d want 0", wr_n - rd_n); end
    drive_done(4'd2, de);
    wait_tx(t0, 2, ok);
    e = exp_tx.pop_front(); void'(exp_tx0.pop_front());
    n_cmp++; if (!ok || tx_log[tx_n-1] !== e) begin n_err++; $display("FAIL ovr_tx: got %h want %h", tx_log[tx_n-1], e); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_reset_mid();
    int t0, de;
    bit ok;
    logic [7:0] e;
    logic [10:0] w;
    send_byte(pat(7, 0), 0);
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL mid_ovr_clear: got %b want 0", overrun); end
    for (int k = 1; k < 40; k++) send_byte(pat(7, k), k);
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front(); n_cmp++;
      if (rd_n >= wr_n) begin n_err++; $display("FAIL mid_write: got none want addr %0d", w[10:1]); end
      else begin
        if ({obs_a[rd_n], obs_b[rd_n]} !== w) begin n_err++; $display("FAIL mid_write: got addr %0d bit %b want addr %0d bit %b", obs_a[rd_n], obs_b[rd_n], w[10:1], w[0]); end
        rd_n++;
      end
    end
    rx_data = 8'hFF; rx_rdy = 1'b1; tick(); rx_rdy = 1'b0;
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({ram_we, ram_wdata, core_start, tx_start, busy, overrun} !== 6'b0 || ram_addr !== 10'd0) begin n_err++; $display("FAIL mid_async_ctl: got we=%b wd=%b cs=%b ts=%b busy=%b ovr=%b addr=%0d want all 0", ram_we, ram_wdata, core_start, tx_start, busy, overrun, ram_addr); end
    n_cmp++; if (tx_data !== 8'h00 || digit !== 4'd0) begin n_err++; $display("FAIL mid_async_data: got tx=%h digit=%0d want 00 0", tx_data, digit); end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    rd_n = wr_n;
    t0 = tx_n;
    send_frame(9);
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front(); n_cmp++;
      if (rd_n >= wr_n) begin n_err++; $display("FAIL mid_refill: got none want addr %0d", w[10:1]); end
      else begin
        if ({obs_a[rd_n], obs_b[rd_n]} !== w) begin n_err++; $display("FAIL mid_refill: got addr %0d bit %b want addr %0d bit %b", obs_a[rd_n], obs_b[rd_n], w[10:1], w[0]); end
        rd_n++;
      end
    end
    drive_done(4'd5, de);
    wait_tx(t0, 2, ok);
    e = exp_tx.pop_front(); void'(exp_tx0.pop_front());
    n_cmp++; if (!ok || tx_log[tx_n-1] !== e || digit !== 4'd5) begin n_err++; $display("FAIL mid_classify: got tx=%h digit=%0d want %h 5", tx_log[tx_n-1], digit, e); end
  endtask

  task automatic test_back_to_back();
    int t0, de;
    bit ok1, ok2;
    logic [7:0] e;
    logic [10:0] w;
    t0 = tx_n;
    send_frame(11);
    drive_done(4'd3, de);
    wait_tx(t0, 1, ok1);
    send_frame(13);
    drive_done(4'd9, de);
    wait_tx(t0 + 1, 2, ok2);
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front(); n_cmp++;
      if (rd_n >= wr_n) begin n_err++; $display("FAIL b2b_write: got none want addr %0d", w[10:1]); end
      else begin
        if ({obs_a[rd_n], obs_b[rd_n]} !== w) begin n_err++; $display("FAIL b2b_write: got addr %0d bit %b want addr %0d bit %b", obs_a[rd_n], obs_b[rd_n], w[10:1], w[0]); end
        rd_n++;
      end
    end
    n_cmp++; if (!ok1 || !ok2 || tx_n - t0 != 2) begin n_err++; $display("FAIL b2b_tx_count: got %0d want 2", tx_n - t0); end
    for (int i = 0; i < 2; i++) begin
      e = exp_tx.pop_front();
      n_cmp++; if (tx_log[t0+i] !== e) begin n_err++; $display("FAIL b2b_tx_data: got %h want %h", tx_log[t0+i], e); end
      e = exp_tx0.pop_front();
      n_cmp++; if (tx0_log[t0+i] !== e) begin n_err++; $display("FAIL b2b_tx_raw: got %h want %h", tx0_log[t0+i], e); end
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_tx_stall();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/snn_frame_ctrl.md
Name: snn_frame_ctrl

Overview:
- Top-level sequencer for the SNN digit classifier.
- Receives a 784-pixel binary image as 98 UART bytes and unpacks each byte into 8 single-bit writes to the input-unit RAM.
- Then starts snn_core, muxes the RAM address between the loader and the core, and sends the classified digit back via UART TX.
- Sits between uart_rx/uart_tx, ram_input_unit and snn_core; it replaces ad-hoc FSM logic in the top module.

Parameters:
- NUM_BITS, 784, pixels per frame; must be a multiple of 8.
- ADDR_W, 10, RAM address width.
- ASCII_OUT, 1, 1: tx_data = 8'h30 + digit; 0: tx_data = {4'h0, digit}.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- rx_rdy  in  1  one-cycle pulse, rx_data valid
- rx_data  in  8  received byte; bit0 = lowest pixel address
- ram_we  out  1  input-RAM write enable
- ram_addr  out  ADDR_W  input-RAM address
- ram_wdata  out  1  input-RAM write bit
- core_addr  in  ADDR_W  snn_core read address
- core_start  out  1  one-cycle start pulse to snn_core
- core_done  in  1  one-cycle pulse, core_digit valid
- core_digit  in  4  classified digit
- tx_start  out  1  one-cycle pulse to uart_tx
- tx_data  out  8  byte to transmit
- tx_rdy  in  1  high while uart_tx is idle
- digit  out  4  last classified digit, for LEDs
- busy  out  1  high in any state other than WAIT_BYTE
- overrun  out  1  sticky byte-dropped flag

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset: all outputs 0, state WAIT_BYTE, byte_cnt=0, bit_cnt=0, load_addr=0, digit=0, overrun=0. Asserting rst mid-operation aborts the frame immediately; the partially written RAM is not cleared.
- ram_addr mux: ram_addr = load_addr in WRITE, else core_addr (combinational).
- ram_we and ram_wdata are 0 outside WRITE.
- WAIT_BYTE:
  - On rx_rdy: latch rx_data into an 8-bit shift register, bit_cnt=0, go to WRITE.
  - If byte_cnt==0, also clear overrun on that same cycle.
- WRITE (exactly 8 cycles):
  - Each cycle: ram_we=1, ram_wdata=shift[0], ram_addr=load_addr. Next cycle shift>>=1, load_addr++, bit_cnt++.
  - After the write with bit_cnt==7: if byte_cnt==NUM_BITS/8-1, go to START (byte_cnt, load_addr reset to 0). Else byte_cnt++ and go to WAIT_BYTE.
  - load_addr never exceeds NUM_BITS-1.
- START: core_start=1 for one cycle, go to WAIT_CORE.
- WAIT_CORE: on core_done, digit<=core_digit and go to SEND.
- SEND:
  - Wait until tx_rdy==1, then tx_start=1 for one cycle, with tx_data valid on that cycle and held until the next SEND.
  - Go to WAIT_TX_LO.
- WAIT_TX_LO: wait for tx_rdy==0, then go to WAIT_TX_HI.
- WAIT_TX_HI: wait for tx_rdy==1, then go to WAIT_BYTE.
- Latency:
  - rx_rdy at cycle N gives RAM writes at N+1..N+8.
  - For the final byte, core_start fires at N+9.
  - core_done at M gives tx_start at M+1 when tx_rdy is already high.
- Overrun: rx_rdy in any state other than WAIT_BYTE drops the byte and sets overrun (sticky). The counters are unaffected.
- Simultaneous events: overrun set and clear on the same cycle cannot occur, because clearing only happens in WAIT_BYTE.
- core_done outside WAIT_CORE is ignored.
- State encoding: 3 bits. Unused encodings return to WAIT_BYTE.

Test Plan:
- Frame of 98 bytes, each 8'hA5 → RAM at addr 8k+i holds bit i of A5 (1,0,1,0,0,1,0,1); ram_we high for exactly 784 cycles total; exactly one core_start, 1 cycle after the last write.
- Full frame, then core_done with core_digit=7 → digit=7, a single tx_start with tx_data=8'h37 (ASCII_OUT=1); with ASCII_OUT=0, tx_data=8'h07.
- tx_rdy held low for 50 cycles at core_done → tx_start is delayed until tx_rdy rises; no pulse is issued while low; busy stays high until the TX completes.
- rx_rdy pulse during WRITE and another during WAIT_CORE → overrun=1, byte_cnt unchanged, frame completes normally; the first byte of the next frame clears overrun.
- rst asserted after 40 bytes → all outputs 0 asynchronously; after release, a fresh 98-byte frame writes from addr 0 and classifies correctly.
- Back-to-back frames: second frame starts immediately after WAIT_TX_HI exits → addressing restarts at 0; two distinct tx_start pulses.
